// File: rtl/wb_slave_mem_if.sv
`default_nettype none
// ============================================================================
// wb_slave_mem_if
// Wishbone classic bus bundle between a master and the wb_slave_mem slave.
// busy_i exists only when WB_SLAVE_MEM_RTY_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
interface wb_slave_mem_if #(
  parameter int ADR_MSB  = 31,
  parameter int DATA_MSB = 31,
  parameter int SEL_MSB  = 3,
  parameter int TAG_MSB  = 3
);
  logic [ADR_MSB:0]  adr_i;
  logic [DATA_MSB:0] dat_i;
  logic [SEL_MSB:0]  sel_i;
  logic              we_i;
  logic              stb_i;
  logic              cyc_i;
  logic [TAG_MSB:0]  tgd_i;
  logic [DATA_MSB:0] dat_o;
  logic [TAG_MSB:0]  tgd_o;
  logic              ack_o;
  logic              err_o;
  logic              rty_o;
`ifdef WB_SLAVE_MEM_RTY_EN
  logic              busy_i;
`endif

  modport master (
`ifdef WB_SLAVE_MEM_RTY_EN
    output busy_i,
`endif
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i, tgd_i,
    input  dat_o, tgd_o, ack_o, err_o, rty_o
  );

  modport slave (
`ifdef WB_SLAVE_MEM_RTY_EN
    input  busy_i,
`endif
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i, tgd_i,
    output dat_o, tgd_o, ack_o, err_o, rty_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_slave_mem.sv
`default_nettype none
// ============================================================================
// wb_slave_mem
// Wishbone slave memory window with programmable wait states, byte-lane
// writes, per-word data tags, and err termination on miss/misalignment.
// Optional macro WB_SLAVE_MEM_RTY_EN adds busy_i and rty_o retry termination.
// Rev 1.0 - initial release
// ============================================================================
module wb_slave_mem #(
  parameter int          ADR_MSB     = 31,
  parameter int          DATA_MSB    = 31,
  parameter int          SEL_MSB     = 3,
  parameter int          TAG_MSB     = 3,
  parameter int          DEPTH_LOG2  = 4,
  parameter int unsigned BASE_ADR    = 0,
  parameter int          WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_slave_mem_if.slave     bus
);

  localparam int               DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [ADR_MSB:0] BASE  = (ADR_MSB + 1)'(BASE_ADR);
  localparam logic [3:0]       WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, TERM, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              capture, enter_term;

  logic [ADR_MSB:0]  adr_q;
  logic [DATA_MSB:0] dat_q;
  logic [SEL_MSB:0]  sel_q;
  logic              we_q;
  logic [TAG_MSB:0]  tgd_q;

  logic [ADR_MSB:0]  req_adr, offset;
  logic [DATA_MSB:0] req_dat;
  logic [SEL_MSB:0]  req_sel;
  logic              req_we;
  logic [TAG_MSB:0]  req_tgd;
  logic              hit, busy;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_MSB:0] mem [DEPTH];
  logic [TAG_MSB:0]  tag [DEPTH];

  logic              ack, err, rty;
  logic [DATA_MSB:0] rd_dat;
  logic [TAG_MSB:0]  rd_tgd;

`ifdef WB_SLAVE_MEM_RTY_EN
  assign busy = bus.busy_i;
`else
  assign busy = 1'b0;
`endif

  // With zero wait states the request terminates on its sampling edge, so the
  // live bus is decoded in IDLE; afterwards only the latched copy is trusted.
  always_comb begin
    req_adr = adr_q;
    req_dat = dat_q;
    req_sel = sel_q;
    req_we  = we_q;
    req_tgd = tgd_q;
    if (state == IDLE) begin
      req_adr = bus.adr_i;
      req_dat = bus.dat_i;
      req_sel = bus.sel_i;
      req_we  = bus.we_i;
      req_tgd = bus.tgd_i;
    end
  end

  // Address decode: subtraction wraps below-base addresses to large values.
  assign offset = req_adr - BASE;
  assign hit    = ((offset >> (DEPTH_LOG2 + 2)) == '0) && (req_adr[1:0] == 2'b00);
  assign idx    = req_adr[DEPTH_LOG2+1:2];

  // State and wait counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; enter_term marks the edge that commits a termination.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_term = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          capture = 1'b1;
          cnt_nxt = WS;
          if (WS != 4'd0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt  = TERM;
            enter_term = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!bus.cyc_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt  = TERM;
          enter_term = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      TERM: state_nxt = DONE;
      DONE: begin
        if (!(bus.cyc_i && bus.stb_i)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, so master changes during WAIT have no effect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      tgd_q <= '0;
    end else if (capture) begin
      adr_q <= bus.adr_i;
      dat_q <= bus.dat_i;
      sel_q <= bus.sel_i;
      we_q  <= bus.we_i;
      tgd_q <= bus.tgd_i;
    end
  end

  // Storage write on the TERM-entry edge; never during reset, never on retry.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_term && hit && !busy && req_we) begin
      for (int i = 0; i <= SEL_MSB; i++) begin
        if (req_sel[i]) mem[idx][i*8 +: 8] <= req_dat[i*8 +: 8];
      end
      if (|req_sel) tag[idx] <= req_tgd;
    end
  end

  // Termination and read-data registers: valid only for the single TERM cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack    <= 1'b0;
      err    <= 1'b0;
      rty    <= 1'b0;
      rd_dat <= '0;
      rd_tgd <= '0;
    end else if (enter_term) begin
      ack    <= hit && !busy;
      err    <= !hit;
      rty    <= hit && busy;
      rd_dat <= (hit && !busy && !req_we) ? mem[idx] : '0;
      rd_tgd <= (hit && !busy && !req_we) ? tag[idx] : '0;
    end else begin
      ack    <= 1'b0;
      err    <= 1'b0;
      rty    <= 1'b0;
      rd_dat <= '0;
      rd_tgd <= '0;
    end
  end

  assign bus.ack_o = ack;
  assign bus.err_o = err;
  assign bus.rty_o = rty;
  assign bus.dat_o = rd_dat;
  assign bus.tgd_o = rd_tgd;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_wb_slave_mem
// Directed self-checking bench for wb_slave_mem (WAIT_STATES=2, BASE=0x100).
// Rev 1.0 - initial release
// ============================================================================
module tb_wb_slave_mem;

  logic clk_i = 1'b0;
  logic rst_i;
  int   errs   = 0;
  int   checks = 0;

  wb_slave_mem_if #(.ADR_MSB(31), .DATA_MSB(31), .SEL_MSB(3), .TAG_MSB(3)) bus ();

  wb_slave_mem #(
    .ADR_MSB(31), .DATA_MSB(31), .SEL_MSB(3), .TAG_MSB(3),
    .DEPTH_LOG2(4), .BASE_ADR(32'h100), .WAIT_STATES(2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] term_now();
    return {bus.ack_o, bus.err_o, bus.rty_o};
  endfunction

  // One transfer. lat = edge (counted from the request edge) at which the
  // master samples the termination; pulses = cycles any termination was high.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [3:0] tgd, input int hold,
                      input bit scramble,
                      output logic [2:0] term, output logic [31:0] rdat,
                      output logic [3:0] rtgd, output int lat, output int pulses);
    bus.we_i = we; bus.adr_i = adr; bus.dat_i = dat; bus.sel_i = sel; bus.tgd_i = tgd;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    term = 3'b000; rdat = '0; rtgd = '0; lat = 0; pulses = 0;
    @(posedge clk_i); #1;
    if (scramble) begin
      bus.we_i = ~we; bus.adr_i = 32'h140; bus.dat_i = '0; bus.sel_i = '0; bus.tgd_i = '0;
    end
    for (int n = 1; n <= 20; n++) begin
      if (term_now() != 3'b000) begin
        term = term_now(); rdat = bus.dat_o; rtgd = bus.tgd_o; lat = n; pulses = 1;
        break;
      end
      @(posedge clk_i); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk_i); #1;
      if (term_now() != 3'b000) pulses++;
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  logic [2:0]  term;
  logic [31:0] rd;
  logic [3:0]  rt;
  int          lat, pul, seen;

  initial begin
    rst_i = 1'b0;
    bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0; bus.we_i = 1'b0;
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0; bus.tgd_i = '0;
`ifdef WB_SLAVE_MEM_RTY_EN
    bus.busy_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outs", {bus.ack_o, bus.err_o, bus.rty_o, bus.dat_o, bus.tgd_o}, 64'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // full-word write, then read back
    xfer(1'b1, 32'h108, 32'hDEADBEEF, 4'hF, 4'h7, 0, 1'b0, term, rd, rt, lat, pul);
    chk("wr_term", term, 3'b100);
    chk("wr_lat", lat, 3);
    chk("wr_pulse_width", pul, 1);
    xfer(1'b0, 32'h108, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("rd_term", term, 3'b100);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_tag", rt, 4'h7);

    // partial lane write; read with sel=0 must not mask data
    xfer(1'b1, 32'h108, 32'h11223344, 4'h3, 4'h5, 0, 1'b0, term, rd, rt, lat, pul);
    xfer(1'b0, 32'h108, 32'h0, 4'h0, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("partial_data", rd, 32'hDEAD3344);
    chk("partial_tag", rt, 4'h5);
    xfer(1'b1, 32'h108, 32'hAA000000, 4'h8, 4'h2, 0, 1'b0, term, rd, rt, lat, pul);
    xfer(1'b0, 32'h108, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("top_lane_data", rd, 32'hAAAD3344);

    // bus scrambled during WAIT: latched request must be used
    xfer(1'b1, 32'h10C, 32'hCAFEF00D, 4'hF, 4'h9, 0, 1'b1, term, rd, rt, lat, pul);
    chk("scramble_term", term, 3'b100);
    xfer(1'b0, 32'h10C, 32'h0, 4'hF, 4'h0, 0, 1'b1, term, rd, rt, lat, pul);
    chk("scramble_rd", rd, 32'hCAFEF00D);
    chk("scramble_tag", rt, 4'h9);

    // misses and misalignment
    xfer(1'b1, 32'h100, 32'h01020304, 4'hF, 4'h1, 0, 1'b0, term, rd, rt, lat, pul);
    xfer(1'b1, 32'h140, 32'hFFFFFFFF, 4'hF, 4'hF, 0, 1'b0, term, rd, rt, lat, pul);
    chk("miss_wr_term", term, 3'b010);
    chk("miss_wr_lat", lat, 3);
    chk("miss_wr_pulse", pul, 1);
    xfer(1'b0, 32'h140, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("miss_rd_term", term, 3'b010);
    chk("miss_rd_data", {rt, rd}, 36'h0);
    xfer(1'b0, 32'h102, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("misalign_term", term, 3'b010);
    chk("misalign_data", {rt, rd}, 36'h0);
    xfer(1'b1, 32'h0FC, 32'hFFFFFFFF, 4'hF, 4'hF, 0, 1'b0, term, rd, rt, lat, pul);
    chk("below_base_term", term, 3'b010);
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("miss_no_store", {rt, rd}, {4'h1, 32'h01020304});
    xfer(1'b0, 32'h13C, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("last_word_hit", term, 3'b100);

    // strobe held after termination: single pulse
    xfer(1'b0, 32'h108, 32'h0, 4'hF, 4'h0, 4, 1'b0, term, rd, rt, lat, pul);
    chk("held_stb_pulses", pul, 1);

    // cyc dropped in WAIT: no termination, no write
    bus.we_i = 1'b1; bus.adr_i = 32'h10C; bus.dat_i = 32'h0; bus.sel_i = 4'hF; bus.tgd_i = 4'h0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk_i); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (term_now() != 3'b000) seen++;
    end
    chk("abort_no_term", seen, 0);
    xfer(1'b0, 32'h10C, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("abort_no_write", rd, 32'hCAFEF00D);

    // reset during WAIT of a write
    xfer(1'b1, 32'h110, 32'h12345678, 4'hF, 4'h3, 0, 1'b0, term, rd, rt, lat, pul);
    bus.we_i = 1'b1; bus.adr_i = 32'h110; bus.dat_i = 32'hFFFFFFFF; bus.sel_i = 4'hF; bus.tgd_i = 4'hF;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("rst_wait_outs", {bus.ack_o, bus.err_o, bus.rty_o, bus.dat_o, bus.tgd_o}, 64'h0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wait_still_zero", {bus.ack_o, bus.err_o, bus.rty_o}, 3'b000);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    xfer(1'b0, 32'h110, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("rst_wait_no_write", {rt, rd}, {4'h3, 32'h12345678});

    // reset asserted while ack is high: outputs drop without a clock edge
    bus.we_i = 1'b0; bus.adr_i = 32'h110; bus.sel_i = 4'hF;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_i); #1;
      if (bus.ack_o) begin seen = 1; break; end
    end
    chk("term_seen_before_rst", seen, 1);
    chk("term_rd_before_rst", bus.dat_o, 32'h12345678);
    rst_i = 1'b0;
    #1;
    chk("rst_term_outs", {bus.ack_o, bus.err_o, bus.rty_o, bus.dat_o, bus.tgd_o}, 64'h0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

`ifdef WB_SLAVE_MEM_RTY_EN
    // retry while busy, then a successful retry
    xfer(1'b1, 32'h114, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    bus.busy_i = 1'b1;
    xfer(1'b1, 32'h114, 32'hAAAA5555, 4'hF, 4'h6, 0, 1'b0, term, rd, rt, lat, pul);
    chk("busy_rty_term", term, 3'b001);
    chk("busy_rty_pulse", pul, 1);
    bus.busy_i = 1'b0;
    xfer(1'b0, 32'h114, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("busy_no_write", {rt, rd}, 36'h0);
    xfer(1'b1, 32'h114, 32'hAAAA5555, 4'hF, 4'h6, 0, 1'b0, term, rd, rt, lat, pul);
    chk("retry_ack", term, 3'b100);
    xfer(1'b0, 32'h114, 32'h0, 4'hF, 4'h0, 0, 1'b0, term, rd, rt, lat, pul);
    chk("retry_written", {rt, rd}, {4'h6, 32'hAAAA5555});
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter ADR_MSB, default 31, MSB of adr_i.
REQ-002 Parameter DATA_MSB, default 31, MSB of dat_i/dat_o.
REQ-003 Parameter SEL_MSB, default 3, MSB of sel_i; one lane per 8 data bits.
REQ-004 Parameter TAG_MSB, default 3, MSB of tag buses.
REQ-005 Parameter DEPTH_LOG2, default 4, storage of 2**DEPTH_LOG2 words.
REQ-006 Parameter BASE_ADR, default 0, word-aligned base address of the window.
REQ-007 Parameter WAIT_STATES, default 2, range 0..15, wait cycles inserted before termination.
REQ-008 clk_i  in  1  single clock; all state on posedge clk_i.
REQ-009 rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-010 adr_i  in  ADR_MSB+1  byte address from master.
REQ-011 dat_i  in  DATA_MSB+1  write data.
REQ-012 sel_i  in  SEL_MSB+1  byte-lane enables.
REQ-013 we_i, stb_i, cyc_i  in  1 each  write enable, strobe, cycle valid.
REQ-014 tgd_i  in  TAG_MSB+1  write-data tag, stored with the word.
REQ-015 dat_o  out  DATA_MSB+1  read data; zero whenever ack_o is low.
REQ-016 tgd_o  out  TAG_MSB+1  tag stored with the read word; zero whenever ack_o is low.
REQ-017 ack_o, err_o, rty_o  out  1 each  registered cycle terminations, mutually exclusive.

Function
REQ-018 Word index SHALL be adr_i[DEPTH_LOG2+1:2]; a hit requires adr_i - BASE_ADR < 4*2**DEPTH_LOG2 and adr_i[1:0]==0.
REQ-019 FSM states SHALL be IDLE, WAIT, TERM, DONE.
REQ-020 IDLE: on an edge sampling cyc_i&stb_i=1, latch adr/we/sel/dat/tgd, load wait counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else TERM.
REQ-021 WAIT: counter decrements each cycle; at 1 go TERM; cyc_i sampled 0 returns to IDLE, no write, no termination (abort).
REQ-022 TERM: exactly one of ack_o/err_o/rty_o high for exactly one cycle; next state DONE.
REQ-023 Termination SHALL occur WAIT_STATES+1 cycles after the edge that sampled the request.
REQ-024 Miss or misalignment SHALL give err_o, no storage change, dat_o=0.
REQ-025 Write hit: on the edge entering TERM, update only lanes with sel bit 1; tag written whenever any sel bit is 1.
REQ-026 Read hit: dat_o/tgd_o present stored word/tag during the TERM cycle; sel_i does not mask read data.
REQ-027 DONE: stay until cyc_i&stb_i sampled 0, then IDLE; a held strobe never re-triggers a transfer.
REQ-028 Request inputs changing during WAIT SHALL be ignored (latched values used).
REQ-029 Storage not cleared by reset; contents after reset undefined.

Reset
REQ-030 rst_i=0 SHALL immediately force state IDLE, counter 0, ack_o=err_o=rty_o=0, dat_o=0, tgd_o=0.
REQ-031 Reset during WAIT or TERM SHALL abort the cycle; no write commits unless its TERM edge occurred before reset.
REQ-032 Operation resumes on the first posedge clk_i with rst_i=1.

Configuration
REQ-033 Macro WB_SLAVE_MEM_RTY_EN defined: extra input busy_i (1 bit); if busy_i=1 on the edge entering TERM for a hit, rty_o replaces ack_o and no write occurs.
REQ-034 Macro undefined: no busy_i port; rty_o tied 0.

Verification
REQ-035 WAIT_STATES=2, write 0xDEADBEEF sel=0xF tgd=0x7 to BASE+0x8 -> ack_o one cycle, 3 cycles after request edge; read BASE+0x8 -> dat_o=0xDEADBEEF, tgd_o=0x7.
REQ-036 Write 0x11223344 sel=0x3 over stored 0xDEADBEEF -> read returns 0xDEAD3344.
REQ-037 Read BASE+0x40 (DEPTH_LOG2=4) and BASE+0x2 -> err_o one cycle, ack_o=0, dat_o=0, storage unchanged.
REQ-038 stb_i/cyc_i held high 4 cycles after ack -> exactly one ack_o pulse; dropping cyc_i in WAIT -> no termination, no write.
REQ-039 rst_i low during WAIT of a write -> outputs 0 immediately, target word unchanged after release.
REQ-040 With WB_SLAVE_MEM_RTY_EN, busy_i=1 write -> rty_o pulse, word unchanged; busy_i=0 retry -> ack_o, word written.
